// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: off, flash-all, run and ping-pong
// modes stepped by a runtime-programmable prescaler.
module led_pattern_gen #(
  parameter int N_LED = 4,
  parameter int DIV_W = 22
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [DIV_W-1:0] PERIOD,
  output logic [N_LED-1:0] LED_OUT,
  output logic             TICK
);

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_FLASH = 2'b01,
    M_RUN   = 2'b10,
    M_PP    = 2'b11
  } mode_t;

  typedef enum logic {
    D_UP = 1'b0,
    D_DN = 1'b1
  } dir_t;

  localparam logic [N_LED-1:0] LED_ONE = N_LED'(1);

  mode_t            r_mode;
  dir_t             r_dir;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_per;
  logic [N_LED-1:0] r_led;
  logic             r_tick;

  mode_t            w_mode_in;
  mode_t            w_mode_nx;
  dir_t             w_dir_nx;
  dir_t             w_step_dir;
  logic [DIV_W-1:0] w_cnt_nx;
  logic [DIV_W-1:0] w_per_nx;
  logic [N_LED-1:0] w_led_nx;
  logic [N_LED-1:0] w_step_led;
  logic             w_tick_nx;
  logic             w_load;
  logic             w_wrap;

  assign w_mode_in = mode_t'(MODE);
  assign w_load    = (w_mode_in != r_mode);
  assign w_wrap    = (r_cnt == r_per);

  // Pattern advance applied on a tick
  always_comb begin
    w_step_led = r_led;
    w_step_dir = r_dir;
    unique case (r_mode)
      M_OFF:   w_step_led = '0;
      M_FLASH: w_step_led = ~r_led;
      M_RUN:   w_step_led = (r_led << 1) | (r_led >> (N_LED - 1));
      M_PP: begin
        if (N_LED == 1) begin
          w_step_led = r_led;
        end else if (r_dir == D_UP) begin
          if (r_led[N_LED-1]) begin
            w_step_dir = D_DN;
            w_step_led = r_led >> 1;
          end else begin
            w_step_led = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_step_dir = D_UP;
            w_step_led = r_led << 1;
          end else begin
            w_step_led = r_led >> 1;
          end
        end
      end
    endcase
  end

  // Mode load outranks the prescaler; EN only gates counting
  always_comb begin
    w_mode_nx = r_mode;
    w_dir_nx  = r_dir;
    w_cnt_nx  = r_cnt;
    w_per_nx  = r_per;
    w_led_nx  = r_led;
    w_tick_nx = 1'b0;
    if (w_load) begin
      w_mode_nx = w_mode_in;
      w_cnt_nx  = '0;
      w_per_nx  = PERIOD;
      w_dir_nx  = D_UP;
      w_led_nx  = MODE[1] ? LED_ONE : '0;
    end else if (EN) begin
      if (w_wrap) begin
        w_cnt_nx  = '0;
        w_per_nx  = PERIOD;
        w_tick_nx = 1'b1;
        w_led_nx  = w_step_led;
        w_dir_nx  = w_step_dir;
      end else begin
        w_cnt_nx = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode <= M_OFF;
      r_dir  <= D_UP;
      r_cnt  <= '0;
      r_per  <= '0;
      r_led  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_mode <= w_mode_nx;
      r_dir  <= w_dir_nx;
      r_cnt  <= w_cnt_nx;
      r_per  <= w_per_nx;
      r_led  <= w_led_nx;
      r_tick <= w_tick_nx;
    end
  end

  assign LED_OUT = r_led;
  assign TICK    = r_tick;

endmodule
